// File: rtl/digit_entry_register.sv
// rtl/digit_entry_register.sv - front-panel digit-by-digit value editor with run/edit handover
// Buttons edit a WIDTH-bit value one decimal/hex digit at a time; execute/stop hand the display to the CPU.
module digit_entry_register #(
  parameter int WIDTH        = 16,
  parameter int DIGITS       = 4,
  parameter int WRAP         = 1,
  parameter int REPEAT_DELAY = 5000000,
  parameter int REPEAT_RATE  = 500000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [WIDTH-1:0]  cpu_value,
  input  logic              execute,
  input  logic              stop,
  input  logic              hex_mode,
  input  logic              move_left,
  input  logic              move_right,
  input  logic              inc,
  input  logic              dec,
  output logic [WIDTH-1:0]  display_value,
  output logic [WIDTH-1:0]  edit_value,
  output logic [DIGITS-1:0] cur_digit,
  output logic              running,
  output logic              limit_hit
);

  localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [WIDTH+3:0] WMAX = {4'b0000, {WIDTH{1'b1}}};

  typedef enum logic {ST_EDIT, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  edit_value_q, edit_value_d;
  logic [DIGITS-1:0] cur_digit_q, cur_digit_d;
  logic [CW-1:0]     rpt_cnt_q, rpt_cnt_d;
  logic              rpt_on_q, rpt_on_d;
  logic              limit_hit_q, limit_hit_d;
  logic              move_left_q, move_right_q, execute_q, stop_q;

  logic              ml_edge, mr_edge, ex_edge, st_edge;
  logic [WIDTH+3:0]  pow, step;
  logic              step_ok, apply;
  logic [WIDTH:0]    sum, diff;

  assign ml_edge = move_left  & ~move_left_q;
  assign mr_edge = move_right & ~move_right_q;
  assign ex_edge = execute    & ~execute_q;
  assign st_edge = stop       & ~stop_q;

  // Power of the base at the cursor; once past the value range it stops growing
  always_comb begin
    pow  = {{(WIDTH+3){1'b0}}, 1'b1};
    step = '0;
    for (int j = 0; j < DIGITS; j++) begin
      if (cur_digit_q[j]) step = pow;
      if (pow <= WMAX) pow = hex_mode ? (pow << 4) : ((pow << 3) + (pow << 1));
    end
  end

  assign step_ok = (step <= WMAX);
  assign sum     = {1'b0, edit_value_q} + {1'b0, step[WIDTH-1:0]};
  assign diff    = {1'b0, edit_value_q} - {1'b0, step[WIDTH-1:0]};

  always_comb begin
    state_d      = state_q;
    edit_value_d = edit_value_q;
    cur_digit_d  = cur_digit_q;
    rpt_cnt_d    = rpt_cnt_q;
    rpt_on_d     = rpt_on_q;
    limit_hit_d  = 1'b0;
    apply        = 1'b0;

    if (st_edge) begin
      state_d      = ST_EDIT;
      edit_value_d = cpu_value;
      rpt_cnt_d    = '0;
      rpt_on_d     = 1'b0;
    end else if (state_q == ST_RUN) begin
      rpt_cnt_d = '0;
      rpt_on_d  = 1'b0;
    end else begin
      if (ex_edge) state_d = ST_RUN;
      if (ml_edge) begin
        cur_digit_d = {cur_digit_q[DIGITS-2:0], cur_digit_q[DIGITS-1]};
        rpt_cnt_d   = '0;
        rpt_on_d    = 1'b0;
      end else if (mr_edge) begin
        cur_digit_d = {cur_digit_q[0], cur_digit_q[DIGITS-1:1]};
        rpt_cnt_d   = '0;
        rpt_on_d    = 1'b0;
      end else if (inc || dec) begin
        // Count zero outside repeat mode means the button was just pressed
        if (!rpt_on_q && rpt_cnt_q == '0) begin
          apply     = 1'b1;
          rpt_cnt_d = CW'(1);
        end else if (!rpt_on_q) begin
          if (rpt_cnt_q == CW'(REPEAT_DELAY)) begin
            apply     = 1'b1;
            rpt_on_d  = 1'b1;
            rpt_cnt_d = CW'(1);
          end else begin
            rpt_cnt_d = rpt_cnt_q + CW'(1);
          end
        end else if (rpt_cnt_q == CW'(REPEAT_RATE)) begin
          apply     = 1'b1;
          rpt_cnt_d = CW'(1);
        end else begin
          rpt_cnt_d = rpt_cnt_q + CW'(1);
        end
      end else begin
        rpt_cnt_d = '0;
        rpt_on_d  = 1'b0;
      end

      if (apply && step_ok) begin
        if (inc) begin
          limit_hit_d  = sum[WIDTH];
          edit_value_d = (sum[WIDTH] && WRAP == 0) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        end else begin
          limit_hit_d  = diff[WIDTH];
          edit_value_d = (diff[WIDTH] && WRAP == 0) ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q      <= ST_EDIT;
      edit_value_q <= '0;
      cur_digit_q  <= {{(DIGITS-1){1'b0}}, 1'b1};
      rpt_cnt_q    <= '0;
      rpt_on_q     <= 1'b0;
      limit_hit_q  <= 1'b0;
      move_left_q  <= 1'b0;
      move_right_q <= 1'b0;
      execute_q    <= 1'b0;
      stop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      edit_value_q <= edit_value_d;
      cur_digit_q  <= cur_digit_d;
      rpt_cnt_q    <= rpt_cnt_d;
      rpt_on_q     <= rpt_on_d;
      limit_hit_q  <= limit_hit_d;
      move_left_q  <= move_left;
      move_right_q <= move_right;
      execute_q    <= execute;
      stop_q       <= stop;
    end
  end

  assign running       = (state_q == ST_RUN);
  assign display_value = running ? cpu_value : edit_value_q;
  assign edit_value    = edit_value_q;
  assign cur_digit     = cur_digit_q;
  assign limit_hit     = limit_hit_q;

endmodule

// File: tb/tb_digit_entry_register.sv
// tb/tb_digit_entry_register.sv - bench for digit_entry_register, wrapping and saturating builds side by side
module tb_digit_entry_register;

  logic        clk = 1'b0;
  logic        rst_n, execute, stop, hex_mode, move_left, move_right, inc, dec;
  logic [15:0] cpu_value;
  logic [15:0] disp_w, edit_w, disp_s, edit_s;
  logic [3:0]  cur_w, cur_s;
  logic        run_w, run_s, lim_w, lim_s;

  int errors = 0;
  int checks = 0;

  // Reference model: index 0 is the wrapping build, index 1 the saturating build
  longint m_ev [2];
  bit     m_lim [2];
  int     m_cur, m_held;
  bit     m_run;
  bit     p_ml, p_mr, p_ex, p_st;

  always #5 clk = ~clk;

  digit_entry_register #(.WIDTH(16), .DIGITS(4), .WRAP(1), .REPEAT_DELAY(10), .REPEAT_RATE(4)) u_wrap (
    .CLK(clk), .RESET(rst_n), .cpu_value(cpu_value), .execute(execute), .stop(stop),
    .hex_mode(hex_mode), .move_left(move_left), .move_right(move_right), .inc(inc), .dec(dec),
    .display_value(disp_w), .edit_value(edit_w), .cur_digit(cur_w), .running(run_w), .limit_hit(lim_w));

  digit_entry_register #(.WIDTH(16), .DIGITS(4), .WRAP(0), .REPEAT_DELAY(10), .REPEAT_RATE(4)) u_sat (
    .CLK(clk), .RESET(rst_n), .cpu_value(cpu_value), .execute(execute), .stop(stop),
    .hex_mode(hex_mode), .move_left(move_left), .move_right(move_right), .inc(inc), .dec(dec),
    .display_value(disp_s), .edit_value(edit_s), .cur_digit(cur_s), .running(run_s), .limit_hit(lim_s));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit ml_e, mr_e, ex_e, st_e, fire;
    longint s, v;
    m_lim[0] = 0;
    m_lim[1] = 0;
    if (!rst_n) begin
      m_ev[0] = 0; m_ev[1] = 0; m_cur = 0; m_run = 0; m_held = 0;
      p_ml = 0; p_mr = 0; p_ex = 0; p_st = 0;
      return;
    end
    ml_e = move_left && !p_ml;
    mr_e = move_right && !p_mr;
    ex_e = execute && !p_ex;
    st_e = stop && !p_st;
    if (st_e) begin
      m_run = 0; m_ev[0] = cpu_value; m_ev[1] = cpu_value; m_held = 0;
    end else if (m_run) begin
      m_held = 0;
    end else begin
      if (ex_e) m_run = 1;
      if (ml_e) begin
        m_cur = (m_cur + 1) % 4; m_held = 0;
      end else if (mr_e) begin
        m_cur = (m_cur + 3) % 4; m_held = 0;
      end else if (inc || dec) begin
        fire = (m_held == 0) || (m_held >= 10 && (m_held - 10) % 4 == 0);
        m_held++;
        if (fire) begin
          s = 1;
          for (int j = 0; j < m_cur; j++) s = s * (hex_mode ? 16 : 10);
          if (s <= 65535) begin
            for (int w = 0; w < 2; w++) begin
              v = inc ? m_ev[w] + s : m_ev[w] - s;
              if (v > 65535) begin
                m_lim[w] = 1; m_ev[w] = (w == 0) ? v - 65536 : 65535;
              end else if (v < 0) begin
                m_lim[w] = 1; m_ev[w] = (w == 0) ? v + 65536 : 0;
              end else begin
                m_ev[w] = v;
              end
            end
          end
        end
      end else begin
        m_held = 0;
      end
    end
    p_ml = move_left; p_mr = move_right; p_ex = execute; p_st = stop;
  endtask

  // One clock with the inputs as currently driven; every output checked against the model
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("edit_wrap", {16'h0, edit_w}, m_ev[0][31:0]);
    chk("edit_sat",  {16'h0, edit_s}, m_ev[1][31:0]);
    chk("cursor",    {28'h0, cur_w}, 32'(1) << m_cur);
    chk("cursor_sat", {28'h0, cur_s}, 32'(1) << m_cur);
    chk("running",   {31'h0, run_w}, {31'h0, m_run});
    chk("limit_wrap", {31'h0, lim_w}, {31'h0, m_lim[0]});
    chk("limit_sat",  {31'h0, lim_s}, {31'h0, m_lim[1]});
    chk("display_wrap", {16'h0, disp_w}, m_run ? {16'h0, cpu_value} : m_ev[0][31:0]);
    chk("display_sat",  {16'h0, disp_s}, m_run ? {16'h0, cpu_value} : m_ev[1][31:0]);
  endtask

  initial begin
    rst_n = 0; execute = 0; stop = 0; hex_mode = 0;
    move_left = 0; move_right = 0; inc = 0; dec = 0; cpu_value = 16'h0;
    tick(); tick();
    chk("reset_edit", {16'h0, edit_w}, 32'd0);
    chk("reset_cursor", {28'h0, cur_w}, 32'b0001);
    chk("reset_running", {31'h0, run_w}, 32'd0);

    rst_n = 1; tick();
    for (int n = 0; n < 2; n++) begin
      move_left = 1; tick(); move_left = 0; tick();
    end
    inc = 1; tick(); inc = 0; tick();
    chk("dec_hundreds_wrap", {16'h0, edit_w}, 32'd100);
    chk("dec_hundreds_sat", {16'h0, edit_s}, 32'd100);
    for (int n = 0; n < 3; n++) begin
      move_right = 1; tick(); move_right = 0; tick();
    end
    chk("cursor_wrap_right", {28'h0, cur_w}, 32'b1000);

    cpu_value = 16'hF000; stop = 1; tick(); stop = 0; tick();
    hex_mode = 1; inc = 1; tick();
    chk("hex_wrap_value", {16'h0, edit_w}, 32'h0000);
    chk("hex_sat_value", {16'h0, edit_s}, 32'hFFFF);
    chk("hex_wrap_limit", {31'h0, lim_w}, 32'd1);
    chk("hex_sat_limit", {31'h0, lim_s}, 32'd1);
    inc = 0; tick();
    chk("limit_one_cycle", {31'h0, lim_w}, 32'd0);

    move_left = 1; tick(); move_left = 0;
    cpu_value = 16'h0000; stop = 1; tick(); stop = 0; tick();
    hex_mode = 0; inc = 1;
    for (int n = 0; n < 30; n++) tick();
    chk("repeat_steps", {16'h0, edit_w}, 32'd6);
    inc = 0; tick();
    inc = 1; tick(); inc = 0; tick();
    chk("repeat_cleared", {16'h0, edit_w}, 32'd7);

    cpu_value = 16'h1234; execute = 1; tick();
    chk("run_running", {31'h0, run_w}, 32'd1);
    chk("run_display", {16'h0, disp_w}, 32'h1234);
    inc = 1; tick(); inc = 0; tick();
    chk("run_inc_ignored", {16'h0, edit_w}, 32'd7);
    stop = 1; tick();
    chk("stop_running", {31'h0, run_w}, 32'd0);
    chk("stop_load", {16'h0, edit_w}, 32'h1234);
    chk("stop_display", {16'h0, disp_w}, 32'h1234);
    execute = 0; stop = 0; tick();

    cpu_value = 16'h0ABC; execute = 1; stop = 1; tick();
    chk("both_edges_edit", {31'h0, run_w}, 32'd0);
    chk("both_edges_load", {16'h0, edit_w}, 32'h0ABC);
    execute = 0; stop = 0; tick();

    execute = 1; tick(); execute = 0; tick();
    rst_n = 0; tick();
    chk("reset_in_run", {31'h0, run_w}, 32'd0);
    chk("reset_in_run_display", {16'h0, disp_w}, 32'd0);
    rst_n = 1; tick();

    for (int n = 0; n < 600; n++) begin
      move_left  = ($urandom % 8 == 0);
      move_right = ($urandom % 8 == 0);
      if ($urandom % 10 == 0) inc = ~inc;
      if ($urandom % 10 == 0) dec = ~dec;
      if ($urandom % 20 == 0) hex_mode = ~hex_mode;
      execute    = ($urandom % 16 == 0);
      stop       = ($urandom % 24 == 0);
      cpu_value  = 16'($urandom);
      rst_n      = ($urandom % 150 != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
